// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - MIPS instruction-fetch stage: PC, I-cache request, IF/ID latch
module fetch_stage #(
    parameter logic [31:0] PC_INIT = 32'h00000000,
    parameter logic [5:0]  HALT_OP = 6'b111111
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic [31:0] iload,
    input  logic        ihit,
    output logic        iREN,
    output logic [31:0] iaddr,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic [31:0] instr_out,
    output logic [31:0] npc_out,
    output logic        valid_out,
    output logic        halted
);

    typedef enum logic [1:0] {
        FETCH  = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2
    } state_t;

    state_t      state;
    logic [31:0] pc;
    logic [31:0] pending_pc;
    logic [31:0] pc_plus4;

    // The outstanding request always targets pc; only HALTED drops the request.
    assign pc_plus4 = pc + 32'd4;
    assign iaddr    = pc;
    assign iREN     = (state != HALTED);
    assign halted   = (state == HALTED);

    // PC, redirect bookkeeping and IF/ID latch update.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state      <= FETCH;
            pc         <= PC_INIT;
            pending_pc <= 32'd0;
            instr_out  <= 32'd0;
            npc_out    <= 32'd0;
            valid_out  <= 1'b0;
        end else begin
            case (state)
                FETCH: begin
                    if (redirect) begin
                        instr_out <= 32'd0;
                        npc_out   <= 32'd0;
                        valid_out <= 1'b0;
                        if (ihit) begin
                            pc <= redirect_pc;
                        end else begin
                            // In-flight miss cannot be cancelled; park the target until it returns.
                            pending_pc <= redirect_pc;
                            state      <= DRAIN;
                        end
                    end else if (stall) begin
                        // Hold everything; a concurrent hit will repeat next cycle.
                        pc <= pc;
                    end else if (ihit) begin
                        pc        <= pc_plus4;
                        instr_out <= iload;
                        npc_out   <= pc_plus4;
                        valid_out <= 1'b1;
                        if (iload[31:26] == HALT_OP) begin
                            state <= HALTED;
                        end
                    end else begin
                        instr_out <= 32'd0;
                        npc_out   <= 32'd0;
                        valid_out <= 1'b0;
                    end
                end
                DRAIN: begin
                    instr_out <= 32'd0;
                    npc_out   <= 32'd0;
                    valid_out <= 1'b0;
                    if (redirect) begin
                        pending_pc <= redirect_pc;
                    end
                    if (ihit) begin
                        // Returned data is wrong-path; jump to the youngest target.
                        pc    <= redirect ? redirect_pc : pending_pc;
                        state <= FETCH;
                    end
                end
                HALTED: begin
                    if (redirect) begin
                        pc        <= redirect_pc;
                        state     <= FETCH;
                        instr_out <= 32'd0;
                        npc_out   <= 32'd0;
                        valid_out <= 1'b0;
                    end
                end
                default: begin
                    state <= FETCH;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - randomized and directed checks of fetch_stage against a behavioural model
module tb_fetch_stage;

    logic        CLK;
    logic        nRST;
    logic [31:0] iload;
    logic        ihit;
    logic        iREN;
    logic [31:0] iaddr;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [31:0] instr_out;
    logic [31:0] npc_out;
    logic        valid_out;
    logic        halted;

    int tests;
    int fails;
    bit check_en;

    // Behavioural model of what decode must see and where fetch must point.
    logic [31:0] m_pc;
    logic [31:0] m_target;
    bit          m_waiting_miss;
    bit          m_stopped;
    logic [31:0] m_instr;
    logic [31:0] m_npc;
    bit          m_valid;

    fetch_stage dut (
        .CLK(CLK),
        .nRST(nRST),
        .iload(iload),
        .ihit(ihit),
        .iREN(iREN),
        .iaddr(iaddr),
        .stall(stall),
        .redirect(redirect),
        .redirect_pc(redirect_pc),
        .instr_out(instr_out),
        .npc_out(npc_out),
        .valid_out(valid_out),
        .halted(halted)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic bubble_model();
        m_instr = 32'd0;
        m_npc   = 32'd0;
        m_valid = 1'b0;
    endtask

    // Model advances on the same edge as the DUT, reading the same stable inputs.
    always @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            m_pc = 32'd0; m_target = 32'd0; m_waiting_miss = 0; m_stopped = 0;
            bubble_model();
        end else if (m_stopped) begin
            if (redirect) begin
                m_stopped = 0;
                m_pc = redirect_pc;
                bubble_model();
            end
        end else if (m_waiting_miss) begin
            bubble_model();
            if (redirect) m_target = redirect_pc;
            if (ihit) begin
                m_pc = m_target;
                m_waiting_miss = 0;
            end
        end else if (redirect) begin
            bubble_model();
            if (ihit) m_pc = redirect_pc;
            else begin
                m_target = redirect_pc;
                m_waiting_miss = 1;
            end
        end else if (stall) begin
            // nothing moves
        end else if (ihit) begin
            m_instr = iload;
            m_npc   = m_pc + 32'd4;
            m_valid = 1'b1;
            m_pc    = m_pc + 32'd4;
            if (iload[31:26] == 6'b111111) m_stopped = 1;
        end else begin
            bubble_model();
        end
    end

    // Every cycle, on the falling edge, the DUT must agree with the model.
    always @(negedge CLK) begin
        if (check_en) begin
            chk("m_iaddr", iaddr, m_pc);
            chk("m_iREN", {31'd0, iREN}, {31'd0, !m_stopped});
            chk("m_halted", {31'd0, halted}, {31'd0, m_stopped});
            chk("m_instr_out", instr_out, m_instr);
            chk("m_npc_out", npc_out, m_npc);
            chk("m_valid_out", {31'd0, valid_out}, {31'd0, m_valid});
        end
    end

    task automatic cyc(input logic h, input logic [31:0] ld, input logic st,
                       input logic rd, input logic [31:0] rpc);
        ihit = h; iload = ld; stall = st; redirect = rd; redirect_pc = rpc;
        @(posedge CLK);
        #2;
    endtask

    task automatic lat(input string name, input logic [31:0] ia, input logic [31:0] ins,
                       input logic [31:0] np, input logic v);
        chk({name, "_iaddr"}, iaddr, ia);
        chk({name, "_instr"}, instr_out, ins);
        chk({name, "_npc"}, npc_out, np);
        chk({name, "_valid"}, {31'd0, valid_out}, {31'd0, v});
    endtask

    initial begin
        tests = 0; fails = 0; check_en = 0;
        nRST = 1'b0; ihit = 0; iload = 0; stall = 0; redirect = 0; redirect_pc = 0;
        repeat (2) @(posedge CLK);
        #2;
        check_en = 1;
        chk("rst_iREN", {31'd0, iREN}, 32'd1);
        chk("rst_halted", {31'd0, halted}, 32'd0);
        lat("rst", 32'h0, 32'h0, 32'h0, 1'b0);
        nRST = 1'b1;

        cyc(1, 32'h20010005, 0, 0, 0); lat("hit0", 32'h4, 32'h20010005, 32'h4, 1);
        cyc(1, 32'h20020003, 0, 0, 0); lat("hit1", 32'h8, 32'h20020003, 32'h8, 1);
        for (int i = 0; i < 3; i++) begin
            cyc(0, 32'h0, 0, 0, 0); lat("miss", 32'h8, 32'h0, 32'h0, 0);
        end
        cyc(1, 32'h00000020, 0, 0, 0); lat("afmiss", 32'hC, 32'h00000020, 32'hC, 1);
        cyc(1, 32'h01234567, 0, 0, 0); lat("to10", 32'h10, 32'h01234567, 32'h10, 1);
        cyc(1, 32'h11111111, 1, 0, 0); lat("stall0", 32'h10, 32'h01234567, 32'h10, 1);
        cyc(1, 32'h11111111, 1, 0, 0); lat("stall1", 32'h10, 32'h01234567, 32'h10, 1);
        cyc(1, 32'h11111111, 0, 0, 0); lat("unstall", 32'h14, 32'h11111111, 32'h14, 1);
        cyc(1, 32'h22222222, 0, 0, 0); lat("to18", 32'h18, 32'h22222222, 32'h18, 1);
        cyc(1, 32'hFC000000, 0, 0, 0); lat("halt", 32'h1C, 32'hFC000000, 32'h1C, 1);
        chk("halt_halted", {31'd0, halted}, 32'd1);
        chk("halt_iREN", {31'd0, iREN}, 32'd0);
        cyc(1, 32'h33333333, 0, 0, 0); lat("halthold", 32'h1C, 32'hFC000000, 32'h1C, 1);
        cyc(0, 32'h0, 0, 1, 32'h100); lat("unhalt", 32'h100, 32'h0, 32'h0, 0);
        chk("unhalt_halted", {31'd0, halted}, 32'd0);
        chk("unhalt_iREN", {31'd0, iREN}, 32'd1);

        cyc(1, 32'h44444444, 0, 1, 32'h20); lat("redir_hit", 32'h20, 32'h0, 32'h0, 0);
        cyc(0, 32'h0, 0, 1, 32'h40); lat("drain_enter", 32'h20, 32'h0, 32'h0, 0);
        cyc(0, 32'h0, 1, 0, 0); lat("drain_wait", 32'h20, 32'h0, 32'h0, 0);
        cyc(1, 32'h55555555, 0, 0, 0); lat("drain_exit", 32'h40, 32'h0, 32'h0, 0);
        cyc(0, 32'h0, 0, 1, 32'h200); lat("drain2_enter", 32'h40, 32'h0, 32'h0, 0);
        cyc(0, 32'h0, 0, 1, 32'h80); lat("drain2_redir", 32'h40, 32'h0, 32'h0, 0);
        cyc(1, 32'h66666666, 0, 0, 0); lat("drain2_exit", 32'h80, 32'h0, 32'h0, 0);

        cyc(1, 32'h0, 0, 1, 32'hFFFFFFFC); lat("to_top", 32'hFFFFFFFC, 32'h0, 32'h0, 0);
        cyc(1, 32'h77777777, 0, 0, 0); lat("wrap", 32'h0, 32'h77777777, 32'h0, 1);

        for (int c = 0; c < 3000; c++) begin
            logic [31:0] ld;
            ld = $urandom;
            if ($urandom_range(0, 19) == 0) ld[31:26] = 6'b111111;
            if (c == 1500) begin
                nRST = 1'b0;
                cyc(0, 32'h0, 0, 0, 0);
                chk("midrst_iaddr", iaddr, 32'h0);
                chk("midrst_valid", {31'd0, valid_out}, 32'd0);
                nRST = 1'b1;
            end
            cyc($urandom_range(0, 9) < 6, ld, $urandom_range(0, 3) == 0,
                $urandom_range(0, 9) == 0, {$urandom_range(0, 255), 2'b00});
        end

        check_en = 0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage of the 5-stage MIPS pipeline, directly upstream of decode.
- Owns the PC register and issues instruction reads to the I-cache.
- Handles cache-miss wait, branch/jump redirects (including a redirect that arrives during an outstanding miss), downstream stalls and halt.
- Drives the IF/ID latch outputs consumed by decode: instruction, PC+4, valid.

Parameters:
PC_INIT, 32'h00000000, PC value loaded on reset.
HALT_OP, 6'b111111, opcode (instr[31:26]) that stops fetching.

Ports:
CLK  in  1  clock, rising edge.
nRST  in  1  asynchronous active-low reset.
iload  in  32  instruction word from I-cache; valid when ihit=1.
ihit  in  1  I-cache has returned iload for iaddr this cycle.
iREN  out  1  instruction read request.
iaddr  out  32  instruction fetch address.
stall  in  1  downstream hazard stall; hold PC and IF/ID latch.
redirect  in  1  taken branch/jump resolved downstream.
redirect_pc  in  32  target address; valid when redirect=1.
instr_out  out  32  IF/ID instruction (0 = nop bubble).
npc_out  out  32  IF/ID PC+4 of instr_out.
valid_out  out  1  IF/ID entry holds a real instruction.
halted  out  1  fetch has stopped on HALT_OP.

Behaviour:
- Reset is nRST, asynchronous, active-low; clock is CLK. On reset: pc=PC_INIT, pending_pc=0, state=FETCH, instr_out=0, npc_out=0, valid_out=0, halted=0.
- Combinational outputs: iREN=(state!=HALTED); iaddr=pc in all states; halted=(state==HALTED). During reset iREN=1 and iaddr=PC_INIT.
- States: FETCH, DRAIN, HALTED. All arithmetic is 32-bit unsigned; pc+4 wraps 32'hFFFFFFFC -> 0. Priority in FETCH is redirect > stall > ihit.
- FETCH, redirect=1, ihit=1: pc<=redirect_pc; latch bubble (instr_out=0, valid_out=0, npc_out=0). Stall is ignored.
- FETCH, redirect=1, ihit=0: pending_pc<=redirect_pc; state<=DRAIN; latch bubble. The cache request cannot be aborted, so iaddr stays at the old pc.
- FETCH, stall=1, no redirect: pc and latch hold. A concurrent ihit is dropped; the hit re-occurs next cycle.
- FETCH, ihit=1, no stall, no redirect:
  - pc<=pc+4; instr_out<=iload; npc_out<=pc+4; valid_out<=1.
  - If iload[31:26]==HALT_OP, also state<=HALTED.
- FETCH, ihit=0, no stall, no redirect: latch bubble; pc holds. Fetch latency is 1 cycle after ihit.
- DRAIN:
  - redirect=1 overwrites pending_pc (youngest target wins).
  - On ihit: discard iload; pc<=pending_pc (or redirect_pc if redirect is asserted that cycle); state<=FETCH.
  - Latch is bubble every DRAIN cycle regardless of stall.
- HALTED:
  - iREN=0; pc and latch hold.
  - redirect=1 means the halt was wrong-path: pc<=redirect_pc, state<=FETCH, latch bubble.
  - Otherwise remains HALTED until reset.
- Reset mid-operation (any state, miss outstanding): immediate return to reset values; the stale ihit is not expected after reset.

Test Plan:
- Reset then ihit=1 every cycle with iload=0x20010005, 0x20020003 -> iaddr 0x0, 0x4, 0x8; instr_out follows one cycle after each hit; npc_out 0x4, 0x8; valid_out=1.
- ihit=0 for 3 cycles at pc=0x8, then ihit -> iaddr held at 0x8, three bubbles (valid_out=0, instr_out=0), then pc=0xC.
- stall=1 for 2 cycles with ihit=1 at pc=0x10 -> pc stays 0x10, latch unchanged; on release, the instruction at 0x10 is latched and pc=0x14.
- redirect=1, redirect_pc=0x40 with ihit=0 at pc=0x20 -> DRAIN, iaddr stays 0x20; on ihit, data discarded, next iaddr=0x40. A second redirect to 0x80 while in DRAIN -> next iaddr=0x80.
- iload=0xFC000000 hit at pc=0x18 -> instr_out=0xFC000000, valid_out=1, halted=1, iREN=0 next cycle; pc stays 0x1C.
- Halted, then redirect=1, redirect_pc=0x100 -> halted=0, latch bubble, iaddr=0x100, iREN=1.
